// File: rtl/sram_store_pkg.sv
// sram_store_pkg
//   Shared definitions for the sram_store word store:
//   - state_t     : FSM state encoding (IDLE / ACCESS / CLEAR)
//   - cnt_width() : width of the wait-state counter, never less than 1 bit
package sram_store_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      CLEAR  = 2'd2
   } state_t;

   // $clog2(1) is 0, so a zero-wait configuration still gets a 1-bit counter.
   function automatic int cnt_width(input int wait_states);
      if (wait_states < 1) begin
         return 1;
      end
      return $clog2(wait_states + 1);
   endfunction

endpackage

// File: rtl/sram_array.sv
// sram_array
//   DEPTH x DATA_WIDTH single-port storage, synchronous write, asynchronous
//   read. No reset: contents survive reset. The caller guarantees addr is in
//   range whenever we is asserted and masks the read data when it is not.
// Ports:
//   clk    in   write clock
//   we     in   write enable, sampled on rising clk
//   addr   in   word address (shared by read and write)
//   wdata  in   write data
//   rdata  out  combinational read of mem[addr]
module sram_array #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 32
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/sram_store.sv
// sram_store
//   Clocked word store with a req/ready/done handshake, programmable wait
//   states and a hardware clear sweep that zeroes every implemented word.
// Ports:
//   clk       in   system clock, rising-edge active
//   reset_n   in   asynchronous active-low reset (control state and rdata)
//   req       in   access request, accepted only while ready
//   we        in   1 = write, 0 = read, sampled with req
//   clr       in   start clear sweep, accepted only while ready, beats req
//   addr      in   word address, captured on acceptance
//   wdata     in   write data, captured on acceptance
//   rdata     out  read result register, updated only on read commit
//   ready     out  high in IDLE
//   done      out  one-cycle pulse after an access or sweep completes
//   clearing  out  high while the sweep runs
module sram_store
   import sram_store_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 5,
   parameter int DEPTH       = 32,
   parameter int WAIT_STATES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req,
   input  logic                  we,
   input  logic                  clr,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  ready,
   output logic                  done,
   output logic                  clearing
);

   localparam int CNT_W = cnt_width(WAIT_STATES);

   // One extra bit so DEPTH == 2**ADDR_WIDTH is still representable.
   localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [CNT_W-1:0]      WAIT_INIT = CNT_W'(WAIT_STATES);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
   logic                    done_q, done_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

   // Request fields captured on acceptance; data path only, never reset.
   logic                    lat_load;
   logic                    lat_we_q;
   logic [ADDR_WIDTH-1:0]   lat_addr_q;
   logic [DATA_WIDTH-1:0]   lat_wdata_q;

   logic                    in_range;
   logic                    arr_we;
   logic [ADDR_WIDTH-1:0]   arr_addr;
   logic [DATA_WIDTH-1:0]   arr_wdata;
   logic [DATA_WIDTH-1:0]   arr_rdata;

   assign in_range = ({1'b0, lat_addr_q} < DEPTH_W);

   sram_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .addr  (arr_addr),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      done_d    = 1'b0;
      rdata_d   = rdata_q;
      lat_load  = 1'b0;
      arr_we    = 1'b0;
      arr_addr  = lat_addr_q;
      arr_wdata = lat_wdata_q;

      unique case (state_q)
         IDLE: begin
            if (clr) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end else if (req) begin
               state_d  = ACCESS;
               cnt_d    = WAIT_INIT;
               lat_load = 1'b1;
            end
         end

         ACCESS: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               // Out-of-range writes are dropped; out-of-range reads return 0.
               if (lat_we_q) begin
                  arr_we = in_range;
               end else begin
                  rdata_d = in_range ? arr_rdata : '0;
               end
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end

         CLEAR: begin
            arr_we    = 1'b1;
            arr_addr  = ptr_q;
            arr_wdata = '0;
            ptr_d     = ptr_q + ADDR_WIDTH'(1);
            if (ptr_q == LAST_ADDR) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Reset forces IDLE asynchronously, so a pending commit or sweep write
   // never reaches the array and done cannot pulse for it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         done_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         done_q  <= done_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (lat_load) begin
         lat_we_q    <= we;
         lat_addr_q  <= addr;
         lat_wdata_q <= wdata;
      end
   end

   assign rdata    = rdata_q;
   assign ready    = (state_q == IDLE);
   assign done     = done_q;
   assign clearing = (state_q == CLEAR);

endmodule

// File: tb/tb_sram_store.sv
// tb_sram_store
//   Directed bench for sram_store. Three instances share clk/reset_n:
//   [0] default 32x32, WAIT_STATES=2; [1] DEPTH=20; [2] WAIT_STATES=0.
module tb_sram_store;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_v      [3];
   logic        we_v       [3];
   logic        clr_v      [3];
   logic [4:0]  addr_v     [3];
   logic [31:0] wdata_v    [3];
   logic [31:0] rdata_v    [3];
   logic        ready_v    [3];
   logic        done_v     [3];
   logic        clearing_v [3];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sram_store #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(32), .WAIT_STATES(2)) u_main (
      .clk(clk), .reset_n(reset_n), .req(req_v[0]), .we(we_v[0]), .clr(clr_v[0]),
      .addr(addr_v[0]), .wdata(wdata_v[0]), .rdata(rdata_v[0]), .ready(ready_v[0]),
      .done(done_v[0]), .clearing(clearing_v[0]));

   sram_store #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(20), .WAIT_STATES(2)) u_small (
      .clk(clk), .reset_n(reset_n), .req(req_v[1]), .we(we_v[1]), .clr(clr_v[1]),
      .addr(addr_v[1]), .wdata(wdata_v[1]), .rdata(rdata_v[1]), .ready(ready_v[1]),
      .done(done_v[1]), .clearing(clearing_v[1]));

   sram_store #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(32), .WAIT_STATES(0)) u_zero (
      .clk(clk), .reset_n(reset_n), .req(req_v[2]), .we(we_v[2]), .clr(clr_v[2]),
      .addr(addr_v[2]), .wdata(wdata_v[2]), .rdata(rdata_v[2]), .ready(ready_v[2]),
      .done(done_v[2]), .clearing(clearing_v[2]));

   // Issues one access and measures edges from acceptance to done (lat) and
   // cycles with ready low (rlow). With immediate=1 the request is driven
   // right away (used from inside a done cycle). Inputs are scrambled after
   // acceptance so a design that re-samples them would be caught.
   task automatic access(input int id, input logic w, input logic [4:0] a,
                         input logic [31:0] d, input bit immediate,
                         output int lat, output int rlow);
      if (!immediate) @(negedge clk);
      req_v[id] = 1'b1; we_v[id] = w; addr_v[id] = a; wdata_v[id] = d;
      @(posedge clk); #1;
      req_v[id] = 1'b0; we_v[id] = ~w; addr_v[id] = ~a; wdata_v[id] = ~d;
      lat  = 0;
      rlow = ready_v[id] ? 0 : 1;
      while (lat < 64) begin
         @(posedge clk); #1;
         lat++;
         if (done_v[id]) break;
         if (!ready_v[id]) rlow++;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_v[i] = 1'b0; we_v[i] = 1'b0; clr_v[i] = 1'b0;
         addr_v[i] = '0; wdata_v[i] = '0;
      end
      #12;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (ready_v[i] !== 1'b1) begin
            failures++; $display("FAIL reset_ready[%0d] got=%b exp=1", i, ready_v[i]);
         end
         checks++;
         if (done_v[i] !== 1'b0) begin
            failures++; $display("FAIL reset_done[%0d] got=%b exp=0", i, done_v[i]);
         end
         checks++;
         if (clearing_v[i] !== 1'b0) begin
            failures++; $display("FAIL reset_clearing[%0d] got=%b exp=0", i, clearing_v[i]);
         end
         checks++;
         if (rdata_v[i] !== 32'h0) begin
            failures++; $display("FAIL reset_rdata[%0d] got=%h exp=0", i, rdata_v[i]);
         end
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_write_read();
      int lat, rlow;
      access(0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, lat, rlow);
      checks++;
      if (lat !== 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", lat); end
      checks++;
      if (rlow !== 3) begin failures++; $display("FAIL wr_ready_low got=%0d exp=3", rlow); end
      @(posedge clk); #1;
      checks++;
      if (done_v[0] !== 1'b0) begin failures++; $display("FAIL wr_done_one_cycle got=%b exp=0", done_v[0]); end
      access(0, 1'b0, 5'd3, 32'h0, 1'b0, lat, rlow);
      checks++;
      if (lat !== 3) begin failures++; $display("FAIL rd_latency got=%0d exp=3", lat); end
      checks++;
      if (rlow !== 3) begin failures++; $display("FAIL rd_ready_low got=%0d exp=3", rlow); end
      checks++;
      if (rdata_v[0] !== 32'hDEADBEEF) begin
         failures++; $display("FAIL rd_data got=%h exp=deadbeef", rdata_v[0]);
      end
   endtask

   task automatic test_clear();
      int lat, rlow, ccount;
      int rd_addr [3] = '{0, 17, 31};
      for (int i = 0; i < 32; i++) access(0, 1'b1, 5'(i), 32'hFFFFFFFF, 1'b0, lat, rlow);
      access(0, 1'b0, 5'd31, 32'h0, 1'b0, lat, rlow);
      checks++;
      if (rdata_v[0] !== 32'hFFFFFFFF) begin
         failures++; $display("FAIL fill_readback got=%h exp=ffffffff", rdata_v[0]);
      end
      @(negedge clk); clr_v[0] = 1'b1;
      @(posedge clk); #1; clr_v[0] = 1'b0;
      ccount = clearing_v[0] ? 1 : 0;
      lat = 0;
      while (lat < 64) begin
         @(posedge clk); #1;
         lat++;
         if (done_v[0]) break;
         if (clearing_v[0]) ccount++;
      end
      checks++;
      if (lat !== 32) begin failures++; $display("FAIL clr_latency got=%0d exp=32", lat); end
      checks++;
      if (ccount !== 32) begin failures++; $display("FAIL clr_clearing_cycles got=%0d exp=32", ccount); end
      checks++;
      if (clearing_v[0] !== 1'b0 || ready_v[0] !== 1'b1) begin
         failures++; $display("FAIL clr_end_flags got=%b%b exp=01", clearing_v[0], ready_v[0]);
      end
      checks++;
      if (rdata_v[0] !== 32'hFFFFFFFF) begin
         failures++; $display("FAIL clr_rdata_hold got=%h exp=ffffffff", rdata_v[0]);
      end
      for (int k = 0; k < 3; k++) begin
         access(0, 1'b0, 5'(rd_addr[k]), 32'h0, 1'b0, lat, rlow);
         checks++;
         if (rdata_v[0] !== 32'h0) begin
            failures++; $display("FAIL clr_read_addr%0d got=%h exp=0", rd_addr[k], rdata_v[0]);
         end
      end
   endtask

   task automatic test_clr_priority();
      int lat, rlow;
      access(0, 1'b1, 5'd9, 32'h00000077, 1'b0, lat, rlow);
      access(0, 1'b0, 5'd9, 32'h0, 1'b0, lat, rlow);
      checks++;
      if (rdata_v[0] !== 32'h00000077) begin
         failures++; $display("FAIL prio_preload got=%h exp=77", rdata_v[0]);
      end
      @(negedge clk);
      clr_v[0] = 1'b1; req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 5'd9; wdata_v[0] = 32'h11111111;
      @(posedge clk); #1;
      clr_v[0] = 1'b0; req_v[0] = 1'b0;
      checks++;
      if (clearing_v[0] !== 1'b1) begin failures++; $display("FAIL prio_clr_wins got=%b exp=1", clearing_v[0]); end
      lat = 0;
      while (lat < 64) begin
         @(posedge clk); #1;
         lat++;
         if (done_v[0]) break;
         if (lat == 3) begin
            req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 5'd9; wdata_v[0] = 32'h22222222;
         end else begin
            req_v[0] = 1'b0;
         end
      end
      req_v[0] = 1'b0;
      checks++;
      if (lat !== 32) begin failures++; $display("FAIL prio_sweep_latency got=%0d exp=32", lat); end
      @(posedge clk); #1;
      checks++;
      if (ready_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
         failures++; $display("FAIL prio_no_queue ready_done got=%b%b exp=10", ready_v[0], done_v[0]);
      end
      access(0, 1'b0, 5'd9, 32'h0, 1'b0, lat, rlow);
      checks++;
      if (rdata_v[0] !== 32'h0) begin failures++; $display("FAIL prio_addr9 got=%h exp=0", rdata_v[0]); end
      // back-to-back: read issued inside the write's done cycle
      access(0, 1'b1, 5'd12, 32'h0BADF00D, 1'b0, lat, rlow);
      access(0, 1'b0, 5'd12, 32'h0, 1'b1, lat, rlow);
      checks++;
      if (lat !== 3 || rlow !== 3) begin
         failures++; $display("FAIL b2b_accept lat_rlow got=%0d/%0d exp=3/3", lat, rlow);
      end
      checks++;
      if (rdata_v[0] !== 32'h0BADF00D) begin
         failures++; $display("FAIL b2b_data got=%h exp=0badf00d", rdata_v[0]);
      end
   endtask

   task automatic test_out_of_range();
      int lat, rlow;
      access(1, 1'b1, 5'd19, 32'hCAFEF00D, 1'b0, lat, rlow);
      access(1, 1'b0, 5'd19, 32'h0, 1'b0, lat, rlow);
      checks++;
      if (rdata_v[1] !== 32'hCAFEF00D) begin
         failures++; $display("FAIL oor_addr19 got=%h exp=cafef00d", rdata_v[1]);
      end
      access(1, 1'b1, 5'd9, 32'h00000009, 1'b0, lat, rlow);
      access(1, 1'b1, 5'd25, 32'h12345678, 1'b0, lat, rlow);
      checks++;
      if (lat !== 3) begin failures++; $display("FAIL oor_write_done got=%0d exp=3", lat); end
      access(1, 1'b0, 5'd25, 32'h0, 1'b0, lat, rlow);
      checks++;
      if (lat !== 3) begin failures++; $display("FAIL oor_read_done got=%0d exp=3", lat); end
      checks++;
      if (rdata_v[1] !== 32'h0) begin failures++; $display("FAIL oor_read_data got=%h exp=0", rdata_v[1]); end
      access(1, 1'b0, 5'd9, 32'h0, 1'b0, lat, rlow);
      checks++;
      if (rdata_v[1] !== 32'h00000009) begin
         failures++; $display("FAIL oor_no_alias got=%h exp=9", rdata_v[1]);
      end
   endtask

   task automatic test_zero_wait();
      int lat, rlow;
      for (int i = 0; i < 3; i++) begin
         access(2, 1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, lat, rlow);
         checks++;
         if (lat !== 1) begin failures++; $display("FAIL zw_write_latency[%0d] got=%0d exp=1", i, lat); end
      end
      @(negedge clk);
      req_v[2] = 1'b1; we_v[2] = 1'b0; addr_v[2] = 5'd0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (ready_v[2] !== 1'b0) begin failures++; $display("FAIL zw_accept[%0d] got=%b exp=0", i, ready_v[2]); end
         addr_v[2] = 5'(i + 1);
         if (i == 2) req_v[2] = 1'b0;
         @(posedge clk); #1;
         checks++;
         if (done_v[2] !== 1'b1) begin failures++; $display("FAIL zw_done[%0d] got=%b exp=1", i, done_v[2]); end
         checks++;
         if (rdata_v[2] !== 32'h100 + 32'(i)) begin
            failures++; $display("FAIL zw_rdata[%0d] got=%h exp=%h", i, rdata_v[2], 32'h100 + 32'(i));
         end
      end
   endtask

   task automatic test_reset_abort();
      int  lat, rlow;
      logic seen_done;
      access(0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, lat, rlow);
      @(negedge clk);
      req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 5'd7; wdata_v[0] = 32'h5A5A5A5A;
      @(posedge clk); #1;
      req_v[0] = 1'b0;
      seen_done = 1'b0;
      @(posedge clk); #1; seen_done |= done_v[0];
      @(posedge clk); #1; seen_done |= done_v[0];
      reset_n = 1'b0;
      #1;
      checks++;
      if (ready_v[0] !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", ready_v[0]); end
      checks++;
      if (rdata_v[0] !== 32'h0) begin failures++; $display("FAIL abort_rdata got=%h exp=0", rdata_v[0]); end
      @(posedge clk); #1; seen_done |= done_v[0];
      checks++;
      if (seen_done !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=0", seen_done); end
      @(negedge clk);
      reset_n = 1'b1;
      access(0, 1'b0, 5'd7, 32'h0, 1'b0, lat, rlow);
      checks++;
      if (rdata_v[0] !== 32'hA5A5A5A5) begin
         failures++; $display("FAIL abort_mem_kept got=%h exp=a5a5a5a5", rdata_v[0]);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_clear();
      test_clr_priority();
      test_out_of_range();
      test_zero_wait();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sram_store.md
Name: sram_store

Overview:
- Parametrised, clocked successor to the discrete 4-bit static RAM model.
- Provides a DATA_WIDTH x DEPTH word store with a req/ready/done handshake.
- Programmable wait states emulate slow static-RAM access time.
- Adds a hardware clear sweep that zeroes the whole store, used as the machine's main store (32 x 32-bit words by default).

Parameters:
DATA_WIDTH, 32, word width in bits; any value >= 1
ADDR_WIDTH, 5, address bus width
DEPTH, 32, number of implemented words; 1 <= DEPTH <= 2**ADDR_WIDTH
WAIT_STATES, 2, extra cycles between request acceptance and commit; 0 allowed

Ports:
clk  input  1  system clock, all state changes on rising edge
reset_n  input  1  asynchronous, active-low reset
req  input  1  access request; sampled only when ready=1
we  input  1  1 = write, 0 = read; sampled with req
clr  input  1  start clear sweep; sampled only when ready=1
addr  input  ADDR_WIDTH  word address, captured on acceptance
wdata  input  DATA_WIDTH  write data, captured on acceptance
rdata  output  DATA_WIDTH  read result register
ready  output  1  high in IDLE; block accepts req/clr
done  output  1  one-cycle pulse when an access or sweep completes
clearing  output  1  high while clear sweep in progress

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, ready=1, done=0, clearing=0, rdata=0, counter=0, pointer=0.
  - Memory contents are not reset.
- States: IDLE, ACCESS, CLEAR.
- IDLE, rising edge:
  - clr=1 -> CLEAR, pointer=0, ready=0, clearing=1. clr has priority over req.
  - else req=1 -> ACCESS. Latch addr, wdata and we; counter=WAIT_STATES; ready=0.
  - else stay in IDLE.
  - done is cleared to 0 on every IDLE edge unless a completion is being signalled.
- ACCESS, rising edge:
  - counter!=0 -> counter decrements.
  - counter==0 -> commit:
    - read: rdata = mem[latched addr].
    - write: mem[latched addr] = latched wdata.
    - Then done=1, ready=1, state=IDLE.
- Latency: if req is accepted at edge E, commit, done and ready all occur at edge E+WAIT_STATES+1. done is high for exactly the one cycle following that edge.
- Back-to-back: a req asserted during the done cycle is accepted at the next edge.
- req/clr while ready=0: ignored, not queued. Changes to addr, wdata or we after acceptance have no effect.
- rdata: changes only on a read commit. It holds through writes and clear sweeps.
- Out of range (latched addr >= DEPTH):
  - read commits rdata=0.
  - write is dropped.
  - done still pulses with normal latency.
- CLEAR, each rising edge: mem[pointer]=0, pointer increments.
  - On the edge writing DEPTH-1: done=1, clearing=0, ready=1, state=IDLE.
  - Sweep acceptance at edge E finishes at edge E+DEPTH.
  - WAIT_STATES does not apply to the sweep.
- Reset mid-operation:
  - Immediate return to IDLE.
  - A pending ACCESS write that has not reached its commit edge is not performed.
  - An interrupted sweep leaves words below pointer zeroed and the rest untouched.
  - done never pulses for an aborted operation.
- WAIT_STATES=0: commit on the edge after acceptance.
- Counter width: $clog2(WAIT_STATES+1), minimum 1. Pointer width: ADDR_WIDTH.

Decomposition:
- Package sram_store_pkg holds:
  - state encoding constants: IDLE=2'd0, ACCESS=2'd1, CLEAR=2'd2;
  - a counter-width helper function.
- Sub-module sram_array holds the DEPTH x DATA_WIDTH storage:
  - single port;
  - synchronous write enable;
  - asynchronous read.
- The FSM, counter, pointer and range check stay in sram_store.

Test Plan:
1. Reset, then write 0xDEADBEEF to addr 3, then read addr 3 (WAIT_STATES=2) -> each done pulses 3 edges after acceptance; rdata=0xDEADBEEF; ready low for exactly 3 cycles per access.
2. Pulse clr after writing all 32 words with 0xFFFFFFFF -> clearing high 32 cycles; done at edge E+32; reads of addr 0, 17 and 31 return 0.
3. Assert req and clr together in IDLE -> sweep runs and the req is ignored. Assert req again during the sweep -> ignored. Assert req in the done cycle -> accepted at the next edge.
4. DEPTH=20, ADDR_WIDTH=5: write 0x12345678 to addr 25, then read addr 25 -> write dropped, read returns 0, done pulses both times. Addr 19 round-trips correctly.
5. Write 0xA5A5A5A5 to addr 7, then start a write of 0x5A5A5A5A to addr 7 and drop reset_n one cycle before commit -> after reset, a read of addr 7 returns 0xA5A5A5A5; done did not pulse for the aborted write; rdata=0 immediately after reset.
6. WAIT_STATES=0 with back-to-back reads of addrs 0, 1, 2 held on the bus -> accepted every second edge; each done follows the next edge; rdata sequence matches the stored words.
